rob_commit_ctrl: RTL and testbench
==================================

ROB_COMMIT_CTRL -- requirements
Module: rob_commit_ctrl

Interface
REQ-001 Parameters: CW=4, commit width; FLUSH_CYC=2, post-flush quiet cycles (1..15).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 hd_valid / hd_ready  in  CW  ROB head window slot 0 (oldest)..3 occupied / executed.
REQ-005 hd_exc, hd_mispred, hd_ebreak, hd_store, hd_rd_en  in  CW each  per-slot flags.
REQ-006 hd_rd_arch, hd_rd_phys, hd_old_phys  in  CW x 8  arch dest, new preg, previous preg.
REQ-007 hd_pc, hd_result, hd_target  in  CW x 32  pc, writeback value, resolved branch target.
REQ-008 mtvec  in  32  exception vector; stall  in  1  blocks all retirement this cycle.
REQ-009 rob_pop_cnt  out  3  entries popped at this edge (combinational).
REQ-010 cm_valid, rat_we, free_en  out  CW each  registered commit bundle masks.
REQ-011 rat_waddr, rat_wdata, free_preg  out  CW x 8; cm_pc, cm_data  out  CW x 32; registered.
REQ-012 flush  out  1; redirect_pc  out  32; halt  out  1; instret  out  64.

Function
REQ-013 States: RUN, QUIET, HALT; retirement evaluated only in RUN with stall=0.
REQ-014 Slot k retires iff slots 0..k-1 retire, hd_valid[k]&hd_ready[k], no older terminating slot, and it is not a second store in the group.
REQ-015 At most one hd_store retires per cycle; second store ends the group before it.
REQ-016 Terminating slot: hd_exc (not retired, not counted in pop), else hd_mispred or hd_ebreak (retired, counted); younger slots discarded.
REQ-017 hd_exc and hd_mispred in same slot: exception wins.
REQ-018 rob_pop_cnt = retired count; on exception, pop also excludes the faulting slot; popped = retired.
REQ-019 Bundle registered: one-cycle latency from pop edge to cm_valid; slot order preserved, packed from bit 0.
REQ-020 rat_we[i]=cm_valid[i]&rd_en&(rd_arch!=0); free_en[i]=rat_we[i], free_preg=old_phys.
REQ-021 Two retired slots with equal rd_arch: both write, higher index wins at consumer; both old pregs freed.
REQ-022 Mispredict or exception: flush=1 for exactly one cycle with bundle; redirect_pc=hd_target or mtvec; state->QUIET.
REQ-023 QUIET: no retirement, pop 0, 4-bit counter from FLUSH_CYC-1 down to 0, then RUN.
REQ-024 ebreak retired: halt set with bundle, state->HALT; HALT is terminal until rst.
REQ-025 instret += retired count each pop edge, 64-bit wrap.
REQ-026 stall=1 in RUN: pop 0, next cm_valid 0; flags ignored.

Reset
REQ-027 rst=1 at edge: state RUN, counter 0, instret 0, all registered outputs 0 incl. flush, halt, redirect_pc.
REQ-028 rst=1 forces rob_pop_cnt=0 combinationally; reset mid-QUIET or HALT returns to RUN next cycle.

Configuration
REQ-029 Macro COMMIT_TRACE_EN: defined -> bundle (cm_valid, rat_we, rat_waddr, rat_wdata, cm_data, cm_pc) fed to DPI commit trace each cycle rst=0; undefined -> no DPI import, ports/timing identical.

Structure
REQ-030 Shared package: CW, FLUSH_CYC defaults, state enum, commit-slot bundle typedef.
REQ-031 One sub-module: commit_select (combinational retire mask, terminating-slot index, store limit).

Verification
REQ-032 All 4 ready, no flags, rd_arch 1..4 -> pop 4, next cycle cm_valid=1111, rat_we=1111, instret+4.
REQ-033 Slot1 not ready, slots 2-3 ready -> pop 1, cm_valid=0001.
REQ-034 Slot1 mispred target 0x80000100 -> pop 2, flush=1, redirect_pc=0x80000100, 2 quiet cycles pop 0.
REQ-035 Slot0 exc+mispred, mtvec 0x80001000 -> pop 0, cm_valid=0000, redirect_pc=0x80001000.
REQ-036 Stores in slots 0 and 2, rd_arch slot 1=0 -> pop 2, rat_we=0001 pattern per rd_en, free_en matches.
REQ-037 Slot2 ebreak -> pop 3, halt=1 held; rst pulse -> halt 0, RUN.

Source files
------------

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared definitions for the ROB commit controller: default sizing,
// FSM state encodings and the per-slot registered commit bundle.
package rob_commit_ctrl_pkg;

    localparam int DEF_CW        = 4;   // commit width (ROB head window slots)
    localparam int DEF_FLUSH_CYC = 2;   // quiet cycles after a flush (1..15)

    // FSM state encodings
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_QUIET = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // One registered commit slot: rename-table write, freed preg, trace data
    typedef struct packed {
        logic [7:0]  rat_waddr;
        logic [7:0]  rat_wdata;
        logic [7:0]  free_preg;
        logic [31:0] pc;
        logic [31:0] data;
    } cm_slot_t;

    // Index width for a slot number within a window of cw slots
    function automatic int slot_idx_w(input int cw);
        return (cw > 1) ? $clog2(cw) : 1;
    endfunction

endpackage

// File: rtl/rob_commit_ctrl_commit_select.sv
// Combinational retire selection over the ROB head window: contiguous
// retire mask from slot 0, terminating-slot classification, and the
// one-store-per-group limit.
module rob_commit_ctrl_commit_select
    import rob_commit_ctrl_pkg::*;
#(
    parameter int CW = DEF_CW,
    parameter int IW = slot_idx_w(DEF_CW)
) (
    input  logic          i_en,
    input  logic [CW-1:0] i_valid,
    input  logic [CW-1:0] i_ready,
    input  logic [CW-1:0] i_exc,
    input  logic [CW-1:0] i_mispred,
    input  logic [CW-1:0] i_ebreak,
    input  logic [CW-1:0] i_store,
    output logic [CW-1:0] o_retire,
    output logic [2:0]    o_cnt,
    output logic          o_term_exc,
    output logic          o_term_mis,
    output logic          o_term_brk,
    output logic [IW-1:0] o_term_idx
);

    // Walk slots oldest-first; the first blocker, exception or redirecting slot ends the group
    always_comb begin
        logic w_stop;
        logic w_store_seen;
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        o_retire     = '0;
        o_cnt        = '0;
        o_term_exc   = 1'b0;
        o_term_mis   = 1'b0;
        o_term_brk   = 1'b0;
        o_term_idx   = '0;
        w_stop       = !i_en;
        w_store_seen = 1'b0;
        for (int k = 0; k < CW; k++) begin
            if (!w_stop) begin
                if (!(i_valid[k] && i_ready[k]) || (i_store[k] && w_store_seen)) begin
                    w_stop = 1'b1;
                end else if (i_exc[k]) begin
                    // Faulting slot is neither retired nor popped; exception beats mispredict
                    o_term_exc = 1'b1;
                    o_term_idx = IW'(k);
                    w_stop     = 1'b1;
                end else begin
                    o_retire[k]  = 1'b1;
                    o_cnt        = o_cnt + 3'd1;
                    w_store_seen = w_store_seen | i_store[k];
                    if (i_mispred[k] || i_ebreak[k]) begin
                        // Mispredict redirect takes precedence if a slot carries both
                        o_term_mis = i_mispred[k];
                        o_term_brk = !i_mispred[k];
                        o_term_idx = IW'(k);
                        w_stop     = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB commit controller: retires up to CW head entries per cycle, emits a
// registered commit bundle, handles flush/redirect, ebreak halt and instret.
// Optional build macro COMMIT_TRACE_EN feeds the registered bundle to a
// commit-trace hook every cycle out of reset; ports and timing are
// unchanged either way.
module rob_commit_ctrl
    import rob_commit_ctrl_pkg::*;
#(
    parameter int CW        = DEF_CW,
    parameter int FLUSH_CYC = DEF_FLUSH_CYC
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [CW-1:0]        i_hd_valid,
    input  logic [CW-1:0]        i_hd_ready,
    input  logic [CW-1:0]        i_hd_exc,
    input  logic [CW-1:0]        i_hd_mispred,
    input  logic [CW-1:0]        i_hd_ebreak,
    input  logic [CW-1:0]        i_hd_store,
    input  logic [CW-1:0]        i_hd_rd_en,
    input  logic [CW-1:0][7:0]   i_hd_rd_arch,
    input  logic [CW-1:0][7:0]   i_hd_rd_phys,
    input  logic [CW-1:0][7:0]   i_hd_old_phys,
    input  logic [CW-1:0][31:0]  i_hd_pc,
    input  logic [CW-1:0][31:0]  i_hd_result,
    input  logic [CW-1:0][31:0]  i_hd_target,
    input  logic [31:0]          i_mtvec,
    input  logic                 i_stall,
    output logic [2:0]           o_rob_pop_cnt,
    output logic [CW-1:0]        o_cm_valid,
    output logic [CW-1:0]        o_rat_we,
    output logic [CW-1:0]        o_free_en,
    output logic [CW-1:0][7:0]   o_rat_waddr,
    output logic [CW-1:0][7:0]   o_rat_wdata,
    output logic [CW-1:0][7:0]   o_free_preg,
    output logic [CW-1:0][31:0]  o_cm_pc,
    output logic [CW-1:0][31:0]  o_cm_data,
    output logic                 o_flush,
    output logic [31:0]          o_redirect_pc,
    output logic                 o_halt,
    output logic [63:0]          o_instret
);

    localparam int IW = slot_idx_w(CW);

    logic [1:0]          r_state;
    logic [3:0]          r_quiet_cnt;
    logic [63:0]         r_instret;
    logic [CW-1:0]       r_cm_valid;
    logic [CW-1:0]       r_rat_we;
    cm_slot_t [CW-1:0]   r_slot;
    logic                r_flush;
    logic [31:0]         r_redirect_pc;
    logic                r_halt;

    logic                w_en;
    logic [CW-1:0]       w_retire;
    logic [2:0]          w_cnt;
    logic                w_term_exc;
    logic                w_term_mis;
    logic                w_term_brk;
    logic [IW-1:0]       w_term_idx;

    // Retirement is only evaluated in RUN, not stalled, not in reset
    assign w_en = !i_rst && (r_state == ST_RUN) && !i_stall;

    rob_commit_ctrl_commit_select #(
        .CW (CW),
        .IW (IW)
    ) u_commit_select (
        .i_en       (w_en),
        .i_valid    (i_hd_valid),
        .i_ready    (i_hd_ready),
        .i_exc      (i_hd_exc),
        .i_mispred  (i_hd_mispred),
        .i_ebreak   (i_hd_ebreak),
        .i_store    (i_hd_store),
        .o_retire   (w_retire),
        .o_cnt      (w_cnt),
        .o_term_exc (w_term_exc),
        .o_term_mis (w_term_mis),
        .o_term_brk (w_term_brk),
        .o_term_idx (w_term_idx)
    );

    // Popped entries equal retired entries; zero outside an enabled RUN cycle
    assign o_rob_pop_cnt = w_cnt;

    // Control FSM: RUN -> QUIET on flush, RUN -> HALT on ebreak, QUIET counts down to RUN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_quiet_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_term_exc || w_term_mis) begin
                        r_state     <= ST_QUIET;
                        r_quiet_cnt <= 4'(FLUSH_CYC - 1);
                    end else if (w_term_brk) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_QUIET: begin
                    if (r_quiet_cnt == '0) r_state <= ST_RUN;
                    else                   r_quiet_cnt <= r_quiet_cnt - 4'd1;
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Registered commit bundle, flush/redirect, halt and retired-instruction counter
    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            r_cm_valid    <= '0;
            r_rat_we      <= '0;
            r_slot        <= '0;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_halt        <= 1'b0;
            r_instret     <= '0;
        end else begin
            r_cm_valid <= w_retire;
            for (int i = 0; i < CW; i++) begin
                r_rat_we[i] <= w_retire[i] && i_hd_rd_en[i] && (i_hd_rd_arch[i] != 8'd0);
                if (w_retire[i]) begin
                    r_slot[i].rat_waddr <= i_hd_rd_arch[i];
                    r_slot[i].rat_wdata <= i_hd_rd_phys[i];
                    r_slot[i].free_preg <= i_hd_old_phys[i];
                    r_slot[i].pc        <= i_hd_pc[i];
                    r_slot[i].data      <= i_hd_result[i];
                end else begin
                    r_slot[i] <= '0;
                end
            end
            r_flush <= w_term_exc || w_term_mis;
            if (w_term_exc)      r_redirect_pc <= i_mtvec;
            else if (w_term_mis) r_redirect_pc <= i_hd_target[w_term_idx];
            if (w_term_brk)      r_halt <= 1'b1;
            r_instret <= r_instret + 64'(w_cnt);
        end
    end

    assign o_cm_valid    = r_cm_valid;
    assign o_rat_we      = r_rat_we;
    assign o_free_en     = r_rat_we;
    assign o_flush       = r_flush;
    assign o_redirect_pc = r_redirect_pc;
    assign o_halt        = r_halt;
    assign o_instret     = r_instret;

    for (genvar g = 0; g < CW; g++) begin : g_out
        assign o_rat_waddr[g] = r_slot[g].rat_waddr;
        assign o_rat_wdata[g] = r_slot[g].rat_wdata;
        assign o_free_preg[g] = r_slot[g].free_preg;
        assign o_cm_pc[g]     = r_slot[g].pc;
        assign o_cm_data[g]   = r_slot[g].data;
    end

`ifdef COMMIT_TRACE_EN
    // Hand the current registered bundle to the trace hook every cycle out of reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            $display("commit_trace valid=%h rat_we=%h waddr=%h wdata=%h data=%h pc=%h",
                     o_cm_valid, o_rat_we, o_rat_waddr, o_rat_wdata, o_cm_data, o_cm_pc);
        end
    end
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed scenarios followed by
// randomized head-window traffic, all checked against a behavioural model.
module tb_rob_commit_ctrl;

    localparam int CW        = 4;
    localparam int FLUSH_CYC = 2;
    localparam int M_RUN     = 0;
    localparam int M_QUIET   = 1;
    localparam int M_HALT    = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [CW-1:0]       hd_valid, hd_ready, hd_exc, hd_mispred, hd_ebreak, hd_store, hd_rd_en;
    logic [CW-1:0][7:0]  hd_rd_arch, hd_rd_phys, hd_old_phys;
    logic [CW-1:0][31:0] hd_pc, hd_result, hd_target;
    logic [31:0]         mtvec;
    logic                stall;

    logic [2:0]          o_rob_pop_cnt;
    logic [CW-1:0]       o_cm_valid, o_rat_we, o_free_en;
    logic [CW-1:0][7:0]  o_rat_waddr, o_rat_wdata, o_free_preg;
    logic [CW-1:0][31:0] o_cm_pc, o_cm_data;
    logic                o_flush, o_halt;
    logic [31:0]         o_redirect_pc;
    logic [63:0]         o_instret;

    // Reference model state
    int                  m_mode;
    int                  m_quiet;
    longint unsigned     m_instret;
    logic [31:0]         m_redirect;
    logic                m_halt;

    int                  n_checks = 0;
    int                  n_pass   = 0;

    always #5 clk = ~clk;

    rob_commit_ctrl #(.CW(CW), .FLUSH_CYC(FLUSH_CYC)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_hd_valid    (hd_valid),
        .i_hd_ready    (hd_ready),
        .i_hd_exc      (hd_exc),
        .i_hd_mispred  (hd_mispred),
        .i_hd_ebreak   (hd_ebreak),
        .i_hd_store    (hd_store),
        .i_hd_rd_en    (hd_rd_en),
        .i_hd_rd_arch  (hd_rd_arch),
        .i_hd_rd_phys  (hd_rd_phys),
        .i_hd_old_phys (hd_old_phys),
        .i_hd_pc       (hd_pc),
        .i_hd_result   (hd_result),
        .i_hd_target   (hd_target),
        .i_mtvec       (mtvec),
        .i_stall       (stall),
        .o_rob_pop_cnt (o_rob_pop_cnt),
        .o_cm_valid    (o_cm_valid),
        .o_rat_we      (o_rat_we),
        .o_free_en     (o_free_en),
        .o_rat_waddr   (o_rat_waddr),
        .o_rat_wdata   (o_rat_wdata),
        .o_free_preg   (o_free_preg),
        .o_cm_pc       (o_cm_pc),
        .o_cm_data     (o_cm_data),
        .o_flush       (o_flush),
        .o_redirect_pc (o_redirect_pc),
        .o_halt        (o_halt),
        .o_instret     (o_instret)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    // Quiet window: every slot valid and ready, no flags, distinct non-zero destinations
    task automatic set_plain();
        rst = 1'b0; stall = 1'b0;
        hd_valid = '1; hd_ready = '1; hd_rd_en = '1;
        hd_exc = '0; hd_mispred = '0; hd_ebreak = '0; hd_store = '0;
        mtvec = $urandom;
        for (int k = 0; k < CW; k++) begin
            hd_rd_arch[k]  = 8'(k + 1);
            hd_rd_phys[k]  = 8'($urandom);
            hd_old_phys[k] = 8'($urandom);
            hd_pc[k]       = $urandom;
            hd_result[k]   = $urandom;
            hd_target[k]   = $urandom;
        end
    endtask

    task automatic set_random();
        stall = ($urandom_range(0, 9) == 0);
        if (m_mode == M_HALT) rst = ($urandom_range(0, 2) == 0);
        else                  rst = ($urandom_range(0, 79) == 0);
        mtvec = $urandom;
        for (int k = 0; k < CW; k++) begin
            hd_valid[k]    = ($urandom_range(0, 9) != 0);
            hd_ready[k]    = ($urandom_range(0, 7) != 0);
            hd_exc[k]      = ($urandom_range(0, 19) == 0);
            hd_mispred[k]  = ($urandom_range(0, 11) == 0);
            hd_ebreak[k]   = ($urandom_range(0, 39) == 0);
            hd_store[k]    = ($urandom_range(0, 2) == 0);
            hd_rd_en[k]    = ($urandom_range(0, 3) != 0);
            hd_rd_arch[k]  = 8'($urandom_range(0, 7));
            hd_rd_phys[k]  = 8'($urandom);
            hd_old_phys[k] = 8'($urandom);
            hd_pc[k]       = $urandom;
            hd_result[k]   = $urandom;
            hd_target[k]   = $urandom;
        end
    endtask

    // One clock: entered at a falling edge with inputs set, checks pop before the
    // rising edge and the registered bundle after it, then returns at the next falling edge.
    task automatic step();
        int n, kind, tk, stores;
        logic [CW-1:0] ev, ewe;
        n = 0; kind = 0; tk = 0; stores = 0;
        #1;
        if (!rst && m_mode == M_RUN && !stall) begin
            for (int k = 0; k < CW; k++) begin
                if (!(hd_valid[k] && hd_ready[k])) break;
                if (hd_store[k] && stores > 0) break;
                if (hd_exc[k]) begin kind = 1; tk = k; break; end
                n++;
                if (hd_store[k]) stores++;
                if (hd_mispred[k]) begin kind = 2; tk = k; break; end
                if (hd_ebreak[k])  begin kind = 3; tk = k; break; end
            end
        end
        check("pop", 64'(o_rob_pop_cnt), 64'(n));
        @(posedge clk);
        #1;
        if (rst) begin
            m_mode = M_RUN; m_quiet = 0; m_instret = 0; m_redirect = '0; m_halt = 1'b0;
        end else begin
            if (m_mode == M_QUIET) begin
                m_quiet--;
                if (m_quiet == 0) m_mode = M_RUN;
            end else if (kind == 1 || kind == 2) begin
                m_mode = M_QUIET;
                m_quiet = FLUSH_CYC;
                m_redirect = (kind == 1) ? mtvec : hd_target[tk];
            end else if (kind == 3) begin
                m_mode = M_HALT;
                m_halt = 1'b1;
            end
            m_instret += longint'(n);
        end
        ev = '0; ewe = '0;
        for (int i = 0; i < n; i++) begin
            ev[i]  = 1'b1;
            ewe[i] = hd_rd_en[i] && (hd_rd_arch[i] != 8'd0);
        end
        check("cm_valid", 64'(o_cm_valid), 64'(ev));
        check("rat_we", 64'(o_rat_we), 64'(ewe));
        check("free_en", 64'(o_free_en), 64'(ewe));
        check("flush", 64'(o_flush), 64'(!rst && (kind == 1 || kind == 2)));
        check("redirect_pc", 64'(o_redirect_pc), 64'(m_redirect));
        check("halt", 64'(o_halt), 64'(m_halt));
        check("instret", o_instret, m_instret);
        for (int i = 0; i < n; i++) begin
            check($sformatf("rat_waddr%0d", i), 64'(o_rat_waddr[i]), 64'(hd_rd_arch[i]));
            check($sformatf("rat_wdata%0d", i), 64'(o_rat_wdata[i]), 64'(hd_rd_phys[i]));
            check($sformatf("free_preg%0d", i), 64'(o_free_preg[i]), 64'(hd_old_phys[i]));
            check($sformatf("cm_pc%0d", i), 64'(o_cm_pc[i]), 64'(hd_pc[i]));
            check($sformatf("cm_data%0d", i), 64'(o_cm_data[i]), 64'(hd_result[i]));
        end
        @(negedge clk);
    endtask

    initial begin
        m_mode = M_RUN; m_quiet = 0; m_instret = 0; m_redirect = '0; m_halt = 1'b0;
        set_plain();
        rst = 1'b1;
        @(negedge clk);
        step();
        check("rst_instret", o_instret, 64'd0);

        // Full-width retire of four plain ops
        set_plain();
        step();
        check("full_valid", 64'(o_cm_valid), 64'hF);
        check("full_instret", o_instret, 64'd4);

        // Slot 1 not ready blocks younger ready slots
        set_plain();
        hd_ready = 4'b1101;
        step();
        check("gap_valid", 64'(o_cm_valid), 64'h1);

        // Mispredict in slot 1, then the quiet window
        set_plain();
        hd_mispred = 4'b0010;
        hd_target[1] = 32'h8000_0100;
        step();
        check("mis_redirect", 64'(o_redirect_pc), 64'h8000_0100);
        check("mis_flush", 64'(o_flush), 64'd1);
        set_plain(); step();
        check("quiet_flush_low", 64'(o_flush), 64'd0);
        set_plain(); step();
        set_plain(); step();
        check("after_quiet_valid", 64'(o_cm_valid), 64'hF);

        // Exception and mispredict in slot 0: exception vector wins
        set_plain();
        hd_exc = 4'b0001; hd_mispred = 4'b0001;
        mtvec = 32'h8000_1000;
        step();
        check("exc_redirect", 64'(o_redirect_pc), 64'h8000_1000);
        check("exc_valid", 64'(o_cm_valid), 64'h0);
        set_plain(); step();
        set_plain(); step();

        // Second store ends the group; slot 1 writes x0
        set_plain();
        hd_store = 4'b0101;
        hd_rd_arch[1] = 8'd0;
        step();
        check("store_rat_we", 64'(o_rat_we), 64'h1);

        // Same destination in two retiring slots: both write, both old pregs freed
        set_plain();
        hd_rd_arch[1] = 8'd5; hd_rd_arch[2] = 8'd5;
        step();

        // ebreak in slot 2 halts until reset
        set_plain();
        hd_ebreak = 4'b0100;
        step();
        check("brk_halt", 64'(o_halt), 64'd1);
        set_plain(); step();
        check("halt_held", 64'(o_halt), 64'd1);
        set_plain(); rst = 1'b1; step();
        check("halt_cleared", 64'(o_halt), 64'd0);
        set_plain(); step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            set_random();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
